pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised successor of the single-bit full adder: WIDTH-bit a+b+cin, carry chain
//  cut into STAGES registered segments for timing closure in wide datapaths.
//  valid/ready streaming interface with full backpressure; sits between operand
//  producers and accumulate/compare logic in the arithmetic datapath.
// PARAMETERS
//  WIDTH   32  operand/sum width in bits; must be a multiple of STAGES
//  STAGES  4   pipeline stages = carry-chain segments; SEG_W = WIDTH/STAGES; 1..WIDTH
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      a/b/cin valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A (unsigned)
//  b          in   WIDTH  operand B (unsigned)
//  cin        in   1      carry in
//  sub        in   1      present only with ADDER_SUB_EN: 1 = a-b
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result bits
//  cout       out  1      carry out of MSB (borrow-not when subtracting)
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids, sum, cout, skew regs -> 0.
//    in_ready = 1 while rst low after release (pipeline empty).
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - Global advance: adv = ~out_valid | out_ready; in_ready = adv (combinational).
//    When adv=0 every stage register holds; no data dropped or duplicated.
//  - Stage k (0..STAGES-1) adds bits [k*SEG_W +: SEG_W] with carry from stage k-1
//    (stage 0 uses cin); upper operand segments ride delay (skew) registers, lower
//    sum segments ride de-skew registers, so result column-aligned at output.
//  - Latency: exactly STAGES cycles from accept to out_valid when out_ready held 1.
//    Throughput 1 result/cycle; bubbles propagate as invalid stages (not collapsed).
//  - Result = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of full sum.
//  - Order preserved: results leave in acceptance order.
//  - Boundary: all-ones + 0 + cin=1 -> carry ripples all segments, sum=0, cout=1.
//    Simultaneous in/out transfer when full: both occur, occupancy unchanged.
//    out_ready low with pipeline full: in_ready low next cycle onward until drained.
//    Reset mid-operation: in-flight results discarded, out_valid drops asynchronously.
//  - Invalid stages still clock data (don't care); only valid bits gate visibility.
// CONFIGURATION
//  ADDER_SUB_EN defined: port sub exists, sampled with a/b; when sub=1 stage inputs use
//    ~b and effective carry-in = 1 (cin ignored); sub travels with its operands.
//  ADDER_SUB_EN undefined: no sub port; add only; logic identical to sub=0.
// STRUCTURE
//  - Package adder_pkg: SEG_W derivation function, parameter legality check macro,
//    typedef stage_t {valid, carry, sum segments, operand remainder}.
//  - One sub-module adder_segment: SEG_W-bit combinational ripple adder
//    (a_seg, b_seg, c_in -> s_seg, c_out), instantiated STAGES times via generate.
//  - Top owns all registers, skew/de-skew arrays, valid chain and adv logic.
// TESTING
//  1 WIDTH=32,STAGES=4: a=0x0000_0001,b=0x0000_0002,cin=0 -> sum=0x3,cout=0 after 4 clk.
//  2 a=0xFFFF_FFFF,b=0,cin=1 -> sum=0,cout=1 (full ripple across all 4 segments).
//  3 Stream 8 back-to-back ops, out_ready=1 -> 8 results on consecutive cycles, in order.
//  4 Full pipe, out_ready=0 for 5 clk -> in_ready=0, sum/out_valid stable; release ->
//    remaining results drain in order, none lost or repeated.
//  5 Assert rst with 3 ops in flight -> out_valid=0 immediately; after release, first new
//    op result appears 4 clk after acceptance.
//  6 ADDER_SUB_EN: a=5,b=7,sub=1 -> sum=0xFFFF_FFFE,cout=0; a=7,b=5,sub=1 -> sum=2,cout=1.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared types and elaboration-time helpers for pipelined_adder.
// The pipeline keeps its per-stage datapath in one flat vector. Each stage k
// holds a word of stage_dw(k) bits laid out as {b_hi, a_hi, sum_lo}:
//   sum_lo - result bits already produced, [0 +: (k+1)*SEG_W]
//   a_hi   - operand A bits still to be added, at their native bit positions
//   b_hi   - operand B bits still to be added, packed above bit WIDTH
// The word shrinks by SEG_W each stage, so every stored bit is consumed
// downstream. stage_off(k) is where stage k's word starts in the flat vector.
package adder_pkg;

    // Per-stage control travelling beside the data word.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_t;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Width of the data word registered by stage k. k = -1 gives the raw
    // {b, a} operand word presented to stage 0.
    function automatic int stage_dw(input int width, input int seg_w, input int k);
        return 2 * width - (k + 1) * seg_w;
    endfunction

    // Offset of stage k's word in the flat pipeline vector; stage_off(STAGES)
    // is the total vector width.
    function automatic int stage_off(input int width, input int seg_w, input int k);
        return 2 * width * k - (seg_w * k * (k + 1)) / 2;
    endfunction

endpackage

// Elaboration guard: WIDTH must split evenly into STAGES segments.
`define ADDER_PARAM_CHECK(W, S) \
    if (!adder_pkg::params_ok(W, S)) begin : g_bad_params \
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH"); \
    end

// File: rtl/adder_segment.sv
// adder_segment: SEG_W-bit combinational ripple-carry adder, one carry-chain
// segment of pipelined_adder.
module adder_segment #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a_seg,
    input  logic [SEG_W-1:0] b_seg,
    input  logic             c_in,
    output logic [SEG_W-1:0] s_seg,
    output logic             c_out
);

    logic [SEG_W:0] carry;

    // Ripple the carry bit by bit through the segment.
    always_comb begin
        carry    = '0;
        s_seg    = '0;
        carry[0] = c_in;
        for (int i = 0; i < SEG_W; i++) begin
            s_seg[i]   = a_seg[i] ^ b_seg[i] ^ carry[i];
            carry[i+1] = (a_seg[i] & b_seg[i]) | (carry[i] & (a_seg[i] ^ b_seg[i]));
        end
    end

    assign c_out = carry[SEG_W];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit a + b + cin with the carry chain cut into STAGES
// registered segments, valid/ready on both sides with full backpressure.
// Optional feature macro: ADDER_SUB_EN adds the 'sub' port (1 = a - b).
// Without it the block is add-only and behaves as if sub were tied to 0.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int SEG_W   = seg_width(WIDTH, STAGES);
    localparam int TOT_W   = stage_off(WIDTH, SEG_W, STAGES);
    localparam int OUT_OFF = stage_off(WIDTH, SEG_W, STAGES - 1);

    `ADDER_PARAM_CHECK(WIDTH, STAGES)

    logic                  adv;
    logic [WIDTH-1:0]      b_eff;
    logic                  cin_eff;
    wire  [TOT_W-1:0]      pipe_d;
    logic [TOT_W-1:0]      pipe_q;
    wire  stage_t [STAGES-1:0] ctrl_d;
    stage_t [STAGES-1:0]   ctrl_q;

    // Subtraction is folded into the operands before they enter the skew
    // registers: a - b = a + ~b + 1, so sub never needs to travel separately.
`ifdef ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // The whole pipeline moves together; a stalled output freezes every stage.
    assign adv      = ~ctrl_q[STAGES-1].valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DWP = stage_dw(WIDTH, SEG_W, k - 1);
        localparam int DWN = stage_dw(WIDTH, SEG_W, k);
        localparam int LO  = k * SEG_W;
        localparam int OFF = stage_off(WIDTH, SEG_W, k);

        logic [DWP-1:0]   prev;
        logic             prev_valid;
        logic             prev_carry;
        logic [SEG_W-1:0] s_seg;
        logic             c_out;
        logic [WIDTH-1:0] low_nxt;

        if (k == 0) begin : g_first
            assign prev       = {b_eff, a};
            assign prev_valid = in_valid;
            assign prev_carry = cin_eff;
        end else begin : g_next
            assign prev       = pipe_q[stage_off(WIDTH, SEG_W, k - 1) +: DWP];
            assign prev_valid = ctrl_q[k-1].valid;
            assign prev_carry = ctrl_q[k-1].carry;
        end

        // Lowest remaining A segment sits at its native position; the lowest
        // remaining B segment is always the first slice above bit WIDTH.
        adder_segment #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a_seg (prev[LO +: SEG_W]),
            .b_seg (prev[WIDTH +: SEG_W]),
            .c_in  (prev_carry),
            .s_seg (s_seg),
            .c_out (c_out)
        );

        // Replace the consumed A segment with its sum segment in place.
        always_comb begin
            low_nxt            = prev[WIDTH-1:0];
            low_nxt[LO +: SEG_W] = s_seg;
        end

        if (k < STAGES - 1) begin : g_skew
            assign pipe_d[OFF +: DWN] = {prev[DWP-1:WIDTH+SEG_W], low_nxt};
        end else begin : g_last
            assign pipe_d[OFF +: DWN] = low_nxt;
        end

        assign ctrl_d[k] = '{valid: prev_valid, carry: c_out};
    end

    // Stage registers: cleared by reset, loaded only when the pipeline advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
            ctrl_q <= '0;
        end else if (adv) begin
            pipe_q <= pipe_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign sum       = pipe_q[OUT_OFF +: WIDTH];
    assign cout      = ctrl_q[STAGES-1].carry;
    assign out_valid = ctrl_q[STAGES-1].valid;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for pipelined_adder (WIDTH=32, STAGES=4).
// Define ADDER_SUB_EN for both DUT and bench to exercise the subtract path.
module tb_pipelined_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub_tb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pops  = 0;
    int run_len = 0;
    int last_pop = -10;
    bit rnd_rdy = 1'b0;

    logic [WIDTH:0] sb[$];

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDER_SUB_EN
        .sub       (sub_tb),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: plain wide arithmetic, subtraction as a + ~b + 1.
    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] ra,
                                               input logic [WIDTH-1:0] rb,
                                               input logic rc, input logic rs);
        logic [WIDTH:0] r;
        if (rs)
            r = {1'b0, ra} + {1'b0, ~rb} + {{WIDTH{1'b0}}, 1'b1};
        else
            r = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus side of the scoreboard: record every accepted operand set.
    always @(negedge clk) begin
        if (rst === 1'b0 && in_valid === 1'b1 && in_ready === 1'b1)
            sb.push_back(ref_sum(a, b, cin, sub_tb));
    end

    // Monitor: compare every delivered result against the head of the queue.
    always @(negedge clk) begin
        logic [WIDTH:0] exp_v;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {cout, sum}, 64'h0);
            end else begin
                exp_v = sb.pop_front();
                chk("result", {cout, sum}, exp_v);
            end
            pops++;
            if (cyc == last_pop + 1) run_len++;
            else run_len = 1;
            last_pop = cyc;
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w;
        case ($urandom_range(0, 5))
            0: w = '0;
            1: w = '1;
            2: w = {WIDTH{1'b1}} >> $urandom_range(0, WIDTH - 1);
            default: w = $urandom;
        endcase
        return w;
    endfunction

    // Present one operand set and hold it until it is accepted.
    task automatic send_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                           input logic tc, input logic ts);
        int waited = 0;
        a = ta; b = tb_v; cin = tc; sub_tb = ts; in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) chk("accept_timeout", 64'(waited), 64'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // One op into an empty pipe with out_ready=1: check latency and value.
    task automatic lat_op(input string name, input logic [WIDTH-1:0] ta,
                          input logic [WIDTH-1:0] tb_v, input logic tc, input logic ts,
                          input logic [WIDTH:0] expv);
        int n;
        a = ta; b = tb_v; cin = tc; sub_tb = ts; in_valid = 1'b1;
        @(posedge clk);
        n = 1;
        #1 in_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 || n >= 20) break;
            @(posedge clk);
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(STAGES));
        chk({name, "_value"}, {cout, sum}, expv);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || out_valid === 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'((sb.size() != 0) || (out_valid === 1'b1)), 64'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub_tb = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_sum", {cout, sum}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_in_ready", 64'(in_ready), 64'h1);

        // Basic add and full carry ripple.
        lat_op("t1", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 33'h0_0000_0003);
        wait_drain("t1_drain");
        lat_op("t2", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 33'h1_0000_0000);
        wait_drain("t2_drain");

        // Eight back-to-back ops come out on consecutive cycles.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_op(rand_word(), rand_word(), 1'(i & 1), 1'b0);
        wait_drain("t3_drain");
        chk("t3_run", 64'(run_len), 64'h8);

        // Fill the pipe with the output stalled, hold 5 cycles, release.
        p0 = pops;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_op(rand_word(), rand_word(), 1'($urandom_range(0, 1)), 1'b0);
        chk("t4_full_valid", 64'(out_valid), 64'h1);
        chk("t4_in_ready_low", 64'(in_ready), 64'h0);
        a = rand_word(); b = rand_word(); cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_in_ready", 64'(in_ready), 64'h0);
            chk("t4_hold_valid", 64'(out_valid), 64'h1);
            chk("t4_hold_sum", {cout, sum}, (sb.size() > 0) ? 64'(sb[0]) : 64'h0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_both_xfer", 64'(in_ready && out_valid), 64'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t4_occupancy_kept", 64'(out_valid), 64'h1);
        wait_drain("t4_drain");
        chk("t4_pop_count", 64'(pops - p0), 64'h5);

        // Reset with three ops in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_op(rand_word(), rand_word(), 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("t5_valid_before", 64'(out_valid), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_drop", 64'(out_valid), 64'h0);
        chk("t5_rst_in_ready", 64'(in_ready), 64'h1);
        chk("t5_rst_sum", {cout, sum}, 64'h0);
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        lat_op("t5", 32'd10, 32'd20, 1'b1, 1'b0, 33'd31);
        wait_drain("t5_drain");

`ifdef ADDER_SUB_EN
        lat_op("t6a", 32'd5, 32'd7, 1'b0, 1'b1, 33'h0_FFFF_FFFE);
        wait_drain("t6a_drain");
        lat_op("t6b", 32'd7, 32'd5, 1'b1, 1'b1, 33'h1_0000_0002);
        wait_drain("t6b_drain");
`endif

        // Random traffic with random backpressure and input bubbles.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
`ifdef ADDER_SUB_EN
            send_op(rand_word(), rand_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
            send_op(rand_word(), rand_word(), 1'($urandom_range(0, 1)), 1'b0);
`endif
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_drain("rand_drain");
        chk("rand_pops", 64'(pops >= 400), 64'h1);
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
